sync_fifo_param: RTL



---
 rtl/sync_fifo_pkg.sv | 30 +++
 rtl/sync_fifo_mem.sv | 33 +++
 rtl/sync_fifo_param.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
// Contents:
//   DEF_DATA_WIDTH / DEF_DEPTH  default geometry
//   ptr_width / level_width     derived widths of the pointers and the fill level
//   fifo_status_t               bundle of status flags, handy for monitors
package sync_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 16;

  // Pointers address DEPTH entries and wrap naturally.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a full FIFO (level == DEPTH) is representable.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow_err;
    logic underflow_err;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_param: simple dual-port RAM with a registered
// write port and a combinational (asynchronous) read port. Not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, combinational from raddr_i
module sync_fifo_mem #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 16,
  localparam int unsigned AddrW    = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrW-1:0]     waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrW-1:0]     raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill level, almost-full/almost-empty
// thresholds, read-valid strobe and sticky overflow/underflow flags.
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word fall-through
// output; without it, reads have a registered one-cycle latency.
// Ports:
//   clock          sole clock, posedge
//   reset          synchronous, active-low
//   write_en       write request, data_in stored when not full
//   data_in        write data
//   read_en        read request, honoured when not empty
//   data_outp      read data
//   read_valid     data_outp carries a popped word (head word in FWFT build)
//   fifo_full      level == DEPTH
//   fifo_empty     level == 0
//   almost_full    level >= AF_THRESH
//   almost_empty   level <= AE_THRESH
//   level          entry count 0..DEPTH
//   overflow_err   sticky: write attempted while full
//   underflow_err  sticky: read attempted while empty
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    read_en,
  output logic [DATA_WIDTH-1:0]   data_outp,
  output logic                    read_valid,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow_err,
  output logic                    underflow_err
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned LvlW = level_width(DEPTH);

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags decode the registered level only, so full/empty arbitration of a
  // simultaneous read+write is always judged on the pre-edge state.
  always_comb begin
    full   = (level_q == LvlW'(DEPTH));
    empty  = (level_q == '0);
    wr_acc = write_en && !full;
    rd_acc = read_en && !empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PtrW'(1);
    level_d = level_q + LvlW'(wr_acc) - LvlW'(rd_acc);
    ovf_d   = ovf_q | (write_en & full);
    unf_d   = unf_q | (read_en & empty);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_mem #(
    .DataWidth (DATA_WIDTH),
    .Depth     (DEPTH)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Tracks the word last shown at the head so the output holds once drained.
  logic [DATA_WIDTH-1:0] last_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q <= '0;
    end else if (!empty) begin
      last_q <= mem_rdata;
    end
  end

  always_comb begin
    data_outp  = empty ? last_q : mem_rdata;
    read_valid = !empty;
  end
`else
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (rd_acc) begin
        data_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    data_outp  = data_q;
    read_valid = valid_q;
  end
`endif

  always_comb begin
    fifo_full     = full;
    fifo_empty    = empty;
    almost_full   = (level_q >= LvlW'(AF_THRESH));
    almost_empty  = (level_q <= LvlW'(AE_THRESH));
    level         = level_q;
    overflow_err  = ovf_q;
    underflow_err = unf_q;
  end

endmodule
